// File: rtl/store_narrow_unit.sv
// store_narrow_unit: narrows a 32-bit register value to byte/halfword/word and
// drives a little-endian, word-wide data memory write port with byte enables.
// Misaligned stores that cross a word boundary are split into two bus beats,
// or rejected with AlignErr when TRAP_MISALIGNED is set.
module store_narrow_unit #(
  parameter int ADDR_WIDTH      = 32,
  parameter bit TRAP_MISALIGNED = 1'b0
) (
  input  logic                  Clk,
  input  logic                  Reset_n,
  input  logic                  ReqValid,
  output logic                  ReqReady,
  input  logic [ADDR_WIDTH-1:0] Addr,
  input  logic [31:0]           WData,
  input  logic [1:0]            Size,
  input  logic                  Signed,
  output logic                  MemValid,
  input  logic                  MemReady,
  output logic [ADDR_WIDTH-1:0] MemAddr,
  output logic [31:0]           MemWData,
  output logic [3:0]            MemByteEn,
  output logic                  Done,
  output logic                  RangeErr,
  output logic                  AlignErr
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_BEAT1,
    S_BEAT2,
    S_RESP,
    S_ERR
  } state_t;

  // Lanes occupied by an access of the given size when it starts at lane 0.
  function automatic logic [3:0] lane_mask(input logic [1:0] size);
    case (size)
      2'b00:   lane_mask = 4'b0001;
      2'b01:   lane_mask = 4'b0011;
      default: lane_mask = 4'b1111;
    endcase
  endfunction

  // True when the value is not the sign/zero extension of its low bytes.
  function automatic logic range_bad(input logic [31:0] v, input logic [1:0] size,
                                     input logic sgn);
    case (size)
      2'b00:   range_bad = sgn ? !((&v[31:7]) || !(|v[31:7])) : (|v[31:8]);
      2'b01:   range_bad = sgn ? !((&v[31:15]) || !(|v[31:15])) : (|v[31:16]);
      default: range_bad = 1'b0;
    endcase
  endfunction

  state_t                  state_q;
  logic                    req_ready_q;
  logic                    mem_valid_q;
  logic [ADDR_WIDTH-1:0]   mem_addr_q;
  logic [31:0]             mem_wdata_q;
  logic [3:0]              mem_be_q;
  logic                    done_q;
  logic                    range_err_q;
  logic                    align_err_q;
  logic                    split_q;
  logic                    rerr_q;
  logic [31:0]             b2_wdata_q;
  logic [3:0]              b2_be_q;

  logic [3:0]              mask_d;
  logic [31:0]             trunc_d;
  logic [7:0]              be_span_d;
  logic [63:0]             data_span_d;
  logic                    split_d;
  logic                    reject_d;
  logic                    rerr_d;

  // Lay the truncated value across two consecutive words: the low word is the
  // first beat, the high word is what spills into the second beat.
  always_comb begin
    mask_d      = lane_mask(Size);
    trunc_d     = WData & {{8{mask_d[3]}}, {8{mask_d[2]}}, {8{mask_d[1]}}, {8{mask_d[0]}}};
    be_span_d   = {4'b0000, mask_d} << Addr[1:0];
    data_span_d = {32'h0000_0000, trunc_d} << {Addr[1:0], 3'b000};
    split_d     = |be_span_d[7:4];
    reject_d    = (Size == 2'b11) || (split_d && TRAP_MISALIGNED);
    rerr_d      = range_bad(WData, Size, Signed);
  end

  // Request FSM; every output is a register so the memory port is glitch-free.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q     <= S_IDLE;
      req_ready_q <= 1'b1;
      mem_valid_q <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_be_q    <= '0;
      done_q      <= 1'b0;
      range_err_q <= 1'b0;
      align_err_q <= 1'b0;
      split_q     <= 1'b0;
      rerr_q      <= 1'b0;
      b2_wdata_q  <= '0;
      b2_be_q     <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (ReqValid) begin
            req_ready_q <= 1'b0;
            if (reject_d) begin
              state_q     <= S_ERR;
              done_q      <= 1'b1;
              align_err_q <= 1'b1;
            end else begin
              state_q     <= S_BEAT1;
              mem_valid_q <= 1'b1;
              mem_addr_q  <= {Addr[ADDR_WIDTH-1:2], 2'b00};
              mem_wdata_q <= data_span_d[31:0];
              mem_be_q    <= be_span_d[3:0];
              split_q     <= split_d;
              b2_wdata_q  <= data_span_d[63:32];
              b2_be_q     <= be_span_d[7:4];
              rerr_q      <= rerr_d;
            end
          end
        end
        S_BEAT1: begin
          if (MemReady) begin
            if (split_q) begin
              state_q     <= S_BEAT2;
              mem_addr_q  <= mem_addr_q + ADDR_WIDTH'(4);
              mem_wdata_q <= b2_wdata_q;
              mem_be_q    <= b2_be_q;
            end else begin
              state_q     <= S_RESP;
              mem_valid_q <= 1'b0;
              done_q      <= 1'b1;
              range_err_q <= rerr_q;
            end
          end
        end
        S_BEAT2: begin
          if (MemReady) begin
            state_q     <= S_RESP;
            mem_valid_q <= 1'b0;
            done_q      <= 1'b1;
            range_err_q <= rerr_q;
          end
        end
        S_RESP: begin
          state_q     <= S_IDLE;
          done_q      <= 1'b0;
          range_err_q <= 1'b0;
          req_ready_q <= 1'b1;
        end
        S_ERR: begin
          state_q     <= S_IDLE;
          done_q      <= 1'b0;
          align_err_q <= 1'b0;
          req_ready_q <= 1'b1;
        end
        default: begin
          state_q     <= S_IDLE;
          req_ready_q <= 1'b1;
          mem_valid_q <= 1'b0;
          done_q      <= 1'b0;
        end
      endcase
    end
  end

  assign ReqReady  = req_ready_q;
  assign MemValid  = mem_valid_q;
  assign MemAddr   = mem_addr_q;
  assign MemWData  = mem_wdata_q;
  assign MemByteEn = mem_be_q;
  assign Done      = done_q;
  assign RangeErr  = range_err_q;
  assign AlignErr  = align_err_q;

endmodule

// File: tb/tb_store_narrow_unit.sv
// Bench for store_narrow_unit: directed spec scenarios plus a randomized run
// compared every cycle against a byte-level reference model.
`timescale 1ns/1ps
module tb_store_narrow_unit;

  logic Clk = 1'b0;
  always #5 Clk = ~Clk;

  logic        Reset_n;
  logic        ReqValid, ReqReady, Sgn, MemValid, MemReady, Done, RangeErr, AlignErr;
  logic [31:0] Addr, WData, MemAddr, MemWData;
  logic [1:0]  Size;
  logic [3:0]  MemByteEn;

  logic        ReqValid_t, ReqReady_t, Sgn_t, MemValid_t, MemReady_t, Done_t, RangeErr_t, AlignErr_t;
  logic [31:0] Addr_t, WData_t, MemAddr_t, MemWData_t;
  logic [1:0]  Size_t;
  logic [3:0]  MemByteEn_t;

  store_narrow_unit #(.ADDR_WIDTH(32), .TRAP_MISALIGNED(1'b0)) dut (
    .Clk(Clk), .Reset_n(Reset_n), .ReqValid(ReqValid), .ReqReady(ReqReady),
    .Addr(Addr), .WData(WData), .Size(Size), .Signed(Sgn),
    .MemValid(MemValid), .MemReady(MemReady), .MemAddr(MemAddr), .MemWData(MemWData),
    .MemByteEn(MemByteEn), .Done(Done), .RangeErr(RangeErr), .AlignErr(AlignErr)
  );

  store_narrow_unit #(.ADDR_WIDTH(32), .TRAP_MISALIGNED(1'b1)) dut_trap (
    .Clk(Clk), .Reset_n(Reset_n), .ReqValid(ReqValid_t), .ReqReady(ReqReady_t),
    .Addr(Addr_t), .WData(WData_t), .Size(Size_t), .Signed(Sgn_t),
    .MemValid(MemValid_t), .MemReady(MemReady_t), .MemAddr(MemAddr_t), .MemWData(MemWData_t),
    .MemByteEn(MemByteEn_t), .Done(Done_t), .RangeErr(RangeErr_t), .AlignErr(AlignErr_t)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name, input string what);
    checks++;
    errors++;
    $display("FAIL %s: %s (t=%0t)", name, what, $time);
  endtask

  // ---------------- reference model ----------------
  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  be;
  } beat_t;

  // Place each stored byte at its own byte address; bytes in the first word
  // form beat 0, bytes in the following word form beat 1.
  function automatic int model_beats(input logic [31:0] a, input logic [31:0] d, input int n,
                                     output beat_t b0, output beat_t b1);
    logic [31:0] ba, wa, first, byte_v;
    logic [1:0]  lane;
    b0 = '0;
    b1 = '0;
    first = a & ~32'd3;
    for (int i = 0; i < n; i++) begin
      ba     = a + 32'(i);
      wa     = ba & ~32'd3;
      lane   = ba[1:0];
      byte_v = (d >> (8 * i)) & 32'hFF;
      if (wa == first) begin
        b0.addr = wa;
        b0.data = b0.data | (byte_v << (8 * lane));
        b0.be   = b0.be | (4'b0001 << lane);
      end else begin
        b1.addr = wa;
        b1.data = b1.data | (byte_v << (8 * lane));
        b1.be   = b1.be | (4'b0001 << lane);
      end
    end
    return (b1.be != 4'b0000) ? 2 : 1;
  endfunction

  // Does the value lie outside the representable range of an n-byte field?
  function automatic bit model_range(input logic [31:0] d, input int n, input bit sg);
    longint v, lo, hi;
    if (n >= 4) return 1'b0;
    if (sg) begin
      v  = longint'($signed(d));
      lo = -(longint'(1) << (8 * n - 1));
      hi = (longint'(1) << (8 * n - 1)) - 1;
    end else begin
      v  = longint'(d);
      lo = 0;
      hi = (longint'(1) << (8 * n)) - 1;
    end
    return (v < lo) || (v > hi);
  endfunction

  // ---------------- per-cycle compare process ----------------
  beat_t       beat_q[$];
  bit          busy = 1'b0;
  bit          exp_rerr, exp_aerr;
  bit          prev_hold = 1'b0;
  logic [31:0] p_addr, p_data;
  logic [3:0]  p_be;
  int          busy_cycles = 0;

  always @(negedge Clk) begin
    beat_t b0, b1;
    int    nb, n;
    if (!Reset_n) begin
      beat_q.delete();
      busy        = 1'b0;
      prev_hold   = 1'b0;
      busy_cycles = 0;
    end else begin
      chk("mon_req_ready", 64'(ReqReady), 64'(!busy));
      if (prev_hold) begin
        chk("mon_hold_valid", 64'(MemValid), 64'(1'b1));
        chk("mon_hold_addr", 64'(MemAddr), 64'(p_addr));
        chk("mon_hold_data", 64'(MemWData), 64'(p_data));
        chk("mon_hold_be", 64'(MemByteEn), 64'(p_be));
      end
      if (MemValid) begin
        if (beat_q.size() == 0) begin
          fail_now("mon_spurious_beat", $sformatf("beat at 0x%0h with none outstanding", MemAddr));
        end else begin
          chk("mon_beat_addr", 64'(MemAddr), 64'(beat_q[0].addr));
          chk("mon_beat_data", 64'(MemWData), 64'(beat_q[0].data));
          chk("mon_beat_be", 64'(MemByteEn), 64'(beat_q[0].be));
          if (MemReady) void'(beat_q.pop_front());
        end
      end
      prev_hold = MemValid && !MemReady;
      p_addr    = MemAddr;
      p_data    = MemWData;
      p_be      = MemByteEn;
      if (Done) begin
        if (!busy) begin
          fail_now("mon_done_unexpected", "Done with no request in flight");
        end else begin
          chk("mon_done_beats_left", 64'(beat_q.size()), 64'(0));
          chk("mon_done_memvalid", 64'(MemValid), 64'(1'b0));
          chk("mon_range_err", 64'(RangeErr), 64'(exp_rerr));
          chk("mon_align_err", 64'(AlignErr), 64'(exp_aerr));
        end
        busy = 1'b0;
      end else if (busy) begin
        busy_cycles++;
        if (busy_cycles > 200) begin
          fail_now("mon_timeout", "request never completed");
          busy = 1'b0;
          beat_q.delete();
        end
      end
      if (ReqValid && ReqReady) begin
        n = (Size == 2'b00) ? 1 : (Size == 2'b01) ? 2 : 4;
        busy        = 1'b1;
        busy_cycles = 0;
        if (Size == 2'b11) begin
          exp_aerr = 1'b1;
          exp_rerr = 1'b0;
        end else begin
          exp_aerr = 1'b0;
          exp_rerr = model_range(WData, n, Sgn);
          nb = model_beats(Addr, WData, n, b0, b1);
          beat_q.push_back(b0);
          if (nb == 2) beat_q.push_back(b1);
        end
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic issue(input logic [31:0] a, input logic [31:0] d, input logic [1:0] s,
                       input logic sg);
    int w = 0;
    while (!ReqReady && w < 100) begin
      step();
      w++;
    end
    if (!ReqReady) fail_now("issue_wait", "ReqReady stuck low");
    Addr = a; WData = d; Size = s; Sgn = sg; ReqValid = 1'b1;
    step();
    ReqValid = 1'b0;
    Addr = $urandom; WData = $urandom; Size = 2'($urandom_range(0, 3)); Sgn = 1'($urandom_range(0, 1));
  endtask

  task automatic issue_t(input logic [31:0] a, input logic [1:0] s);
    Addr_t = a; WData_t = 32'h1234_5678; Size_t = s; Sgn_t = 1'b0; ReqValid_t = 1'b1;
    step();
    ReqValid_t = 1'b0;
  endtask

  function automatic logic [31:0] rand_addr();
    case ($urandom_range(0, 2))
      0:       return $urandom;
      1:       return 32'h100 + 32'($urandom_range(0, 31));
      default: return 32'hFFFF_FFFC + 32'($urandom_range(0, 3));
    endcase
  endfunction

  function automatic logic [31:0] rand_data();
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] bl [0:9];
    bl = '{32'h7F, 32'h80, 32'hFF, 32'h100, 32'hFFFF_FF7F, 32'hFFFF_FF80,
           32'h7FFF, 32'h8000, 32'hFFFF_8000, 32'hFFFF_7FFF};
    b = 8'($urandom);
    h = 16'($urandom);
    case ($urandom_range(0, 5))
      0:       return $urandom;
      1:       return {{24{b[7]}}, b};
      2:       return {{16{h[15]}}, h};
      3:       return 32'($urandom_range(0, 511));
      4:       return 32'($urandom_range(0, 131071));
      default: return bl[$urandom_range(0, 9)];
    endcase
  endfunction

  // ---------------- main sequence ----------------
  initial begin
    beat_t b0, b1;
    int    nb, r;
    Reset_n = 1'b0; ReqValid = 1'b0; Addr = '0; WData = '0; Size = '0; Sgn = 1'b0; MemReady = 1'b1;
    ReqValid_t = 1'b0; Addr_t = '0; WData_t = '0; Size_t = '0; Sgn_t = 1'b0; MemReady_t = 1'b1;

    // Pin the reference model to hand-computed values.
    nb = model_beats(32'h3FF, 32'h0000_A55A, 2, b0, b1);
    chk("model_split_n", 64'(nb), 64'(2));
    chk("model_split_b0", 64'({b0.addr, b0.be}), 64'({32'h3FC, 4'b1000}));
    chk("model_split_b0d", 64'(b0.data), 64'(32'h5A00_0000));
    chk("model_split_b1", 64'({b1.addr, b1.be}), 64'({32'h400, 4'b0001}));
    chk("model_split_b1d", 64'(b1.data), 64'(32'h0000_00A5));
    nb = model_beats(32'h202, 32'hFFFF_FF80, 1, b0, b1);
    chk("model_byte", 64'({b0.data, b0.be}), 64'({32'h0080_0000, 4'b0100}));
    chk("model_rng_s180", 64'(model_range(32'h180, 1, 1'b1)), 64'(1));
    chk("model_rng_sff80", 64'(model_range(32'hFFFF_FF80, 1, 1'b1)), 64'(0));
    chk("model_rng_h8000s", 64'(model_range(32'h8000, 2, 1'b1)), 64'(1));
    chk("model_rng_h8000u", 64'(model_range(32'h8000, 2, 1'b0)), 64'(0));

    repeat (3) @(posedge Clk);
    #1;
    chk("rst_req_ready", 64'(ReqReady), 64'(1));
    chk("rst_mem_valid", 64'(MemValid), 64'(0));
    chk("rst_done_errs", 64'({Done, RangeErr, AlignErr}), 64'(0));
    chk("rst_mem_addr", 64'(MemAddr), 64'(0));
    chk("rst_mem_wdata", 64'(MemWData), 64'(0));
    chk("rst_mem_be", 64'(MemByteEn), 64'(0));
    Reset_n = 1'b1;
    step();

    // Aligned word, MemReady tied high: beat at N+1, Done at N+2.
    issue(32'h100, 32'hDEAD_BEEF, 2'b10, 1'b0);
    chk("aw_valid", 64'(MemValid), 64'(1));
    chk("aw_addr", 64'(MemAddr), 64'(32'h100));
    chk("aw_be", 64'(MemByteEn), 64'(4'b1111));
    chk("aw_data", 64'(MemWData), 64'(32'hDEAD_BEEF));
    chk("aw_busy", 64'({ReqReady, Done}), 64'(0));
    step();
    chk("aw_done", 64'({Done, RangeErr, AlignErr, MemValid}), 64'(4'b1000));
    step();
    chk("aw_ready_back", 64'({ReqReady, Done}), 64'(2'b10));

    // Signed byte at offset 2, in range then out of range.
    issue(32'h202, 32'hFFFF_FF80, 2'b00, 1'b1);
    chk("bs_be", 64'(MemByteEn), 64'(4'b0100));
    chk("bs_data", 64'(MemWData), 64'(32'h0080_0000));
    step();
    chk("bs_done", 64'({Done, RangeErr}), 64'(2'b10));
    step();
    issue(32'h202, 32'h0000_0180, 2'b00, 1'b1);
    chk("br_data", 64'(MemWData), 64'(32'h0080_0000));
    step();
    chk("br_done", 64'({Done, RangeErr}), 64'(2'b11));
    step();

    // Split halfword across a word boundary.
    issue(32'h3FF, 32'h0000_A55A, 2'b01, 1'b0);
    chk("sh_b1", 64'({MemValid, MemAddr, MemByteEn}), 64'({1'b1, 32'h3FC, 4'b1000}));
    chk("sh_b1_data", 64'(MemWData), 64'(32'h5A00_0000));
    step();
    chk("sh_b2", 64'({MemValid, MemAddr, MemByteEn}), 64'({1'b1, 32'h400, 4'b0001}));
    chk("sh_b2_data", 64'(MemWData), 64'(32'h0000_00A5));
    step();
    chk("sh_done", 64'({Done, RangeErr, AlignErr}), 64'(3'b100));
    step();

    // Backpressure: beat held stable for 5 cycles.
    MemReady = 1'b0;
    issue(32'h104, 32'h1234_5678, 2'b10, 1'b0);
    for (int i = 0; i < 5; i++) begin
      chk("bp_hold", 64'({MemValid, MemAddr, MemByteEn}), 64'({1'b1, 32'h104, 4'b1111}));
      chk("bp_hold_data", 64'(MemWData), 64'(32'h1234_5678));
      chk("bp_hold_ctl", 64'({ReqReady, Done}), 64'(0));
      step();
    end
    MemReady = 1'b1;
    step();
    chk("bp_done", 64'({Done, MemValid}), 64'(2'b10));
    step();

    // Illegal size rejected without a beat.
    issue(32'h100, 32'h0, 2'b11, 1'b0);
    chk("ill_done", 64'({Done, AlignErr, MemValid}), 64'(3'b110));
    step();
    chk("ill_after", 64'({Done, AlignErr, ReqReady}), 64'(3'b001));

    // Trapping instance: misaligned split and illegal size rejected at N+1.
    issue_t(32'h101, 2'b10);
    chk("trap_mis", 64'({Done_t, AlignErr_t, MemValid_t}), 64'(3'b110));
    step();
    chk("trap_mis_after", 64'({Done_t, ReqReady_t, MemValid_t}), 64'(3'b010));
    issue_t(32'h100, 2'b11);
    chk("trap_ill", 64'({Done_t, AlignErr_t, MemValid_t}), 64'(3'b110));
    step();
    issue_t(32'h101, 2'b00);
    chk("trap_nosplit", 64'({MemValid_t, MemAddr_t, MemByteEn_t}), 64'({1'b1, 32'h100, 4'b0010}));
    chk("trap_nosplit_data", 64'(MemWData_t), 64'(32'h0000_7800));
    step();
    chk("trap_nosplit_done", 64'({Done_t, AlignErr_t}), 64'(2'b10));
    step();

    // Asynchronous reset while the second beat is pending.
    issue(32'h3FE, 32'hCAFE_F00D, 2'b10, 1'b0);
    chk("rb_b1", 64'({MemAddr, MemByteEn}), 64'({32'h3FC, 4'b1100}));
    step();
    MemReady = 1'b0;
    chk("rb_b2", 64'({MemValid, MemAddr, MemByteEn}), 64'({1'b1, 32'h400, 4'b0011}));
    #2;
    Reset_n = 1'b0;
    #1;
    chk("rb_async", 64'({MemValid, ReqReady, Done, MemByteEn}), 64'(7'b0100000));
    @(posedge Clk);
    #1;
    Reset_n = 1'b1;
    MemReady = 1'b1;
    step();
    issue(32'h108, 32'h55AA_55AA, 2'b10, 1'b0);
    chk("rb_next", 64'({MemValid, MemAddr, MemByteEn}), 64'({1'b1, 32'h108, 4'b1111}));
    step();
    chk("rb_next_done", 64'(Done), 64'(1));
    step();

    // Randomized traffic checked by the compare process.
    for (int c = 0; c < 4000; c++) begin
      MemReady = ($urandom_range(0, 3) != 0);
      ReqValid = 1'($urandom_range(0, 1));
      Addr     = rand_addr();
      WData    = rand_data();
      r        = int'($urandom_range(0, 9));
      Size     = (r < 3) ? 2'b00 : (r < 6) ? 2'b01 : (r < 9) ? 2'b10 : 2'b11;
      Sgn      = 1'($urandom_range(0, 1));
      step();
    end
    ReqValid = 1'b0;
    MemReady = 1'b1;
    repeat (20) step();
    chk("end_idle", 64'({busy, ReqReady}), 64'(2'b01));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
